chip8_keymatrix_scan: RTL and testbench

Scans a physical 4x4 hex keypad matrix and produces the debounced 16-bit key vector `keys_raw` that feeds `chip8_top`. It sits directly upstream of the top-level keypad input. It drives one active-low column at a time, samples the four active-low rows through a synchronizer, and debounces each key independently. Bit `k` of `keys_raw` is CHIP-8 key `k` (0x0–0xF).

---
 rtl/chip8_pkg.sv | 23 ++
 rtl/chip8_key_debounce.sv | 73 +++++++
 rtl/chip8_keymatrix_scan.sv | 99 +++++++++
 tb/tb_chip8_keymatrix_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// chip8_pkg: keypad geometry and physical-to-CHIP-8 key mapping
// shared by the keypad matrix scanner and its debounce cells.
package chip8_pkg;

   localparam int KEY_ROWS = 4;
   localparam int KEY_COLS = 4;

   typedef logic [3:0] key_idx_t;

   localparam key_idx_t KEYPAD_MAP [KEY_ROWS][KEY_COLS] = '{
      '{4'h1, 4'h2, 4'h3, 4'hC},
      '{4'h4, 4'h5, 4'h6, 4'hD},
      '{4'h7, 4'h8, 4'h9, 4'hE},
      '{4'hA, 4'h0, 4'hB, 4'hF}
   };

   function automatic logic [KEY_COLS-1:0] col_drive(
      input logic [1:0] col
   );
      col_drive = ~(4'b0001 << col);
   endfunction

endpackage

// File: rtl/chip8_key_debounce.sv
// chip8_key_debounce: one key's stable state, flip counter and change pulse.
// KEYSCAN_DEBOUNCE_EN builds the counter; otherwise samples pass straight in.
module chip8_key_debounce
   import chip8_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic smp_i,
   output logic stable_o,
   output logic change_o
);

   logic stable_q, stable_d;
   logic change_q, change_d;

`ifdef KEYSCAN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // count consecutive disagreeing samples, flip on the last one
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      change_d = 1'b0;
      if (en_i) begin
         if (smp_i == stable_q) begin
            cnt_d = '0;
         end else if (32'(cnt_q) + 1 < DEBOUNCE_SCANS) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            stable_d = smp_i;
            cnt_d    = '0;
            change_d = 1'b1;
         end
      end
   end

   // disagreement counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   // every differing sample becomes the new stable state
   always_comb begin
      stable_d = stable_q;
      change_d = 1'b0;
      if (en_i && (smp_i != stable_q)) begin
         stable_d = smp_i;
         change_d = 1'b1;
      end
   end
`endif

   // stable state and one-cycle change pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q <= 1'b0;
         change_q <= 1'b0;
      end else begin
         stable_q <= stable_d;
         change_q <= change_d;
      end
   end

   assign stable_o = stable_q;
   assign change_o = change_q;

endmodule

// File: rtl/chip8_keymatrix_scan.sv
// chip8_keymatrix_scan: 4x4 hex keypad column scanner with per-key debounce.
// Define KEYSCAN_DEBOUNCE_EN to build the debounce counters.
module chip8_keymatrix_scan
   import chip8_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [KEY_ROWS-1:0] row_n,
   output logic [KEY_COLS-1:0] col_n,
   output logic [15:0]         keys_raw,
   output logic [15:0]         key_change,
   output logic                frame_done
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [KEY_ROWS-1:0] sync1_q, sync2_q;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [1:0]          col_q, col_d;
   logic                frame_q, frame_d;
   logic                sample_pt;
   logic [KEY_ROWS-1:0] pressed;

   logic [KEY_ROWS*KEY_COLS-1:0] st_rc;
   logic [KEY_ROWS*KEY_COLS-1:0] chg_rc;

   // two-flop synchronizer, reset to released rows
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= row_n;
         sync2_q <= sync1_q;
      end
   end

   assign pressed   = ~sync2_q;
   assign sample_pt = (dwell_q == DW'(SCAN_DIV - 1));

   // dwell/column advance and end-of-frame strobe
   always_comb begin
      dwell_d = dwell_q + 1'b1;
      col_d   = col_q;
      frame_d = 1'b0;
      if (sample_pt) begin
         dwell_d = '0;
         col_d   = col_q + 2'd1;
         frame_d = (col_q == 2'd3);
      end
   end

   // scan position registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dwell_q <= '0;
         col_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         dwell_q <= dwell_d;
         col_q   <= col_d;
         frame_q <= frame_d;
      end
   end

   assign col_n      = col_drive(col_q);
   assign frame_done = frame_q;

   for (genvar r = 0; r < KEY_ROWS; r++) begin : g_row
      for (genvar c = 0; c < KEY_COLS; c++) begin : g_col
         chip8_key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_db (
            .clk     (clk),
            .reset   (reset),
            .en_i    (sample_pt && (col_q == 2'(c))),
            .smp_i   (pressed[r]),
            .stable_o(st_rc[r*KEY_COLS+c]),
            .change_o(chg_rc[r*KEY_COLS+c])
         );
      end
   end

   // route matrix positions to CHIP-8 key numbers
   always_comb begin
      keys_raw   = '0;
      key_change = '0;
      for (int r = 0; r < KEY_ROWS; r++) begin
         for (int c = 0; c < KEY_COLS; c++) begin
            keys_raw[KEYPAD_MAP[r][c]]   = st_rc[r*KEY_COLS+c];
            key_change[KEYPAD_MAP[r][c]] = chg_rc[r*KEY_COLS+c];
         end
      end
   end

endmodule

// File: tb/tb_chip8_keymatrix_scan.sv
// tb_chip8_keymatrix_scan: keypad matrix model plus cycle-level reference
// for the scanner; works with KEYSCAN_DEBOUNCE_EN defined or not.
module tb_chip8_keymatrix_scan;

   localparam int SD = 8;
   localparam int DS = 3;
`ifdef KEYSCAN_DEBOUNCE_EN
   localparam int DEB = DS;
`else
   localparam int DEB = 1;
`endif

   localparam logic [3:0] MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hC},
      '{4'h4, 4'h5, 4'h6, 4'hD},
      '{4'h7, 4'h8, 4'h9, 4'hE},
      '{4'hA, 4'h0, 4'hB, 4'hF}
   };

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [15:0] keys_raw;
   logic [15:0] key_change;
   logic        frame_done;
   logic [15:0] press = 16'h0;

   int checks = 0;
   int errors = 0;
   int st = 0;
   int chg_seen = 0;

   int          cyc = 0;
   logic [15:0] m_stable = 16'h0;
   int          m_cnt [16];
   logic [15:0] e_chg = 16'h0;
   logic        e_fd = 1'b0;
   logic [15:0] h1 = 16'h0;
   logic [15:0] h2 = 16'h0;
   logic [3:0]  ec;

   chip8_keymatrix_scan #(
      .SCAN_DIV      (SD),
      .DEBOUNCE_SCANS(DS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row_n     (row_n),
      .col_n     (col_n),
      .keys_raw  (keys_raw),
      .key_change(key_change),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_n[c] && press[MAP[r][c]]) row_n[r] = 1'b0;
   end

   function automatic void chk(string name, logic [15:0] act,
                               logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_col", {12'h0, col_n}, 16'h000E);
         chk("rst_keys", keys_raw, 16'h0);
         chk("rst_chg", key_change, 16'h0);
         chk("rst_fd", {15'h0, frame_done}, 16'h0);
         cyc = 0;
         m_stable = 16'h0;
         for (int k = 0; k < 16; k++) m_cnt[k] = 0;
         e_chg = 16'h0;
         e_fd = 1'b0;
         h1 = 16'h0;
         h2 = 16'h0;
      end else begin
         ec = 4'hF;
         ec[(cyc / SD) % 4] = 1'b0;
         chk("col", {12'h0, col_n}, {12'h0, ec});
         chk("keys", keys_raw, m_stable);
         chk("chg", key_change, e_chg);
         chk("fd", {15'h0, frame_done}, {15'h0, e_fd});
         if (key_change != 16'h0) chg_seen++;
         e_chg = 16'h0;
         e_fd = 1'b0;
         if (cyc % SD == SD - 1) begin
            automatic int c = (cyc / SD) % 4;
            for (int r = 0; r < 4; r++) begin
               automatic int k = int'(MAP[r][c]);
               if (h2[k] == m_stable[k]) begin
                  m_cnt[k] = 0;
               end else if (m_cnt[k] + 1 < DEB) begin
                  m_cnt[k]++;
               end else begin
                  m_stable[k] = h2[k];
                  m_cnt[k] = 0;
                  e_chg[k] = 1'b1;
               end
            end
            e_fd = (c == 3);
         end
         h2 = h1;
         h1 = press;
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         st++;
      end
   endtask

   task automatic to(input int t);
      while (st < t) step(1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1'b0;
      step(3);
      reset = 1'b1;
      st = 0;
   endtask

   initial begin
      int t;
      step(3);
      reset = 1'b1;
      st = 0;

      chk("t1_col0", {12'h0, col_n}, 16'h000E);
      to(7);
      chk("t1_col7", {12'h0, col_n}, 16'h000E);
      to(8);
      chk("t1_col8", {12'h0, col_n}, 16'h000D);
      to(16);
      chk("t1_col16", {12'h0, col_n}, 16'h000B);
      to(24);
      chk("t1_col24", {12'h0, col_n}, 16'h0007);
      to(31);
      chk("t1_fd31", {15'h0, frame_done}, 16'h0);
      to(32);
      chk("t1_fd32", {15'h0, frame_done}, 16'h1);
      chk("t1_col32", {12'h0, col_n}, 16'h000E);
      chk("t1_keys", keys_raw, 16'h0);
      to(33);
      chk("t1_fd33", {15'h0, frame_done}, 16'h0);

      do_reset();
      press = 16'h0040;
      t = 24 + 32 * (DEB - 1);
      to(t - 1);
      chk("t2_pre", keys_raw, 16'h0);
      to(t);
      chk("t2_on", keys_raw, 16'h0040);
      chk("t2_onchg", key_change, 16'h0040);
      to(t + 1);
      chk("t2_onchg1", key_change, 16'h0);
      to(96);
      press = 16'h0;
      t = 120 + 32 * (DEB - 1);
      to(t - 1);
      chk("t2_held", keys_raw, 16'h0040);
      to(t);
      chk("t2_off", keys_raw, 16'h0);
      chk("t2_offchg", key_change, 16'h0040);
      to(t + 1);
      chk("t2_offchg1", key_change, 16'h0);

      do_reset();
      chg_seen = 0;
      for (int i = 0; i < 4; i++) begin
         press = 16'h0040;
         step(32);
         press = 16'h0;
         step(32);
      end
      step(40);
      chk("t3_keys", keys_raw, 16'h0);
`ifdef KEYSCAN_DEBOUNCE_EN
      chk("t3_nochg", 16'(chg_seen), 16'h0);
`endif

      do_reset();
      press = 16'h9000;
      t = 32 + 32 * (DEB - 1);
      to(t - 1);
      chk("t4_pre", keys_raw, 16'h0);
      to(t);
      chk("t4_on", keys_raw, 16'h9000);
      chk("t4_chg", key_change, 16'h9000);
      to(t + 1);
      chk("t4_chg1", key_change, 16'h0);
      press = 16'h0;
      step(100);

      do_reset();
      press = 16'h0001;
      to(48);
`ifdef KEYSCAN_DEBOUNCE_EN
      chk("t5_partial", keys_raw, 16'h0);
`endif
      do_reset();
      chk("t5_rstcol", {12'h0, col_n}, 16'h000E);
      chk("t5_rstkeys", keys_raw, 16'h0);
      t = 16 + 32 * (DEB - 1);
      to(t - 1);
      chk("t5_pre", keys_raw, 16'h0);
      to(t);
      chk("t5_on", keys_raw, 16'h0001);
      press = 16'h0;
      step(100);

      do_reset();
      press = 16'h0400;
      t = 8 + 32 * (DEB - 1);
      to(t - 1);
      chk("t6_pre", keys_raw, 16'h0);
      to(t);
      chk("t6_on", keys_raw, 16'h0400);
      step(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
